uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter among `NUM_REQ` byte producers. It grants one requester at a time and latches that requester's byte onto the UART `DataIN`. It holds the UART `EN` for the whole frame and waits for the transmitter's completion pulse, with a watchdog timeout. It then enforces a minimum idle gap before re-arbitrating. It sits between the system's byte sources and the `UART` block.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..16.
- `IDLE_GAP`, default 2: idle cycles between frames; 0 allowed.
- `TIMEOUT_CYCLES`, default 64: maximum cycles in SEND awaiting `TxDone`; must be ≥ 2.

Ports (clock and reset first):
- `CLK  input  1`: single clock; all logic on rising edge.
- `Reset  input  1`: reset, synchronous and active-low (0 = reset).
- `Req  input  NUM_REQ`: level request per requester; held until its `Ack`.
- `ReqData  input  8*NUM_REQ`: byte for requester i on bits [8i+7:8i].
- `Ack  output  NUM_REQ`: one-cycle pulse; byte of requester i has been captured.
- `GrantId  output  $clog2(NUM_REQ)`: index of the current or most recent owner.
- `Busy  output  1`: high in SEND and GAP.
- `EN  output  1`: UART enable; high for the full frame.
- `DataIN  output  8`: byte presented to the UART; stable while `EN` is high.
- `TxDone  input  1`: one-cycle pulse from the UART at frame end.
- `Timeout  output  1`: one-cycle pulse when the watchdog aborts a frame.

## Operation
- States: IDLE, SEND, GAP.
- **IDLE**
  - With any `Req` bit set, select the first set bit searching from `last+1` mod `NUM_REQ`, upward with wrap.
  - On that edge, register all of the following:
    - `GrantId` ← selected index.
    - `DataIN` ← selected `ReqData` byte.
    - `last` ← selected index.
    - `Ack[sel]` ← 1.
    - `EN` ← 1.
    - Watchdog ← 0.
    - State → SEND.
  - With no `Req` bit set, remain in IDLE.
- **SEND**
  - `EN` stays 1 and `DataIN` is held. The watchdog increments every cycle.
  - On `TxDone`=1: `EN` ← 0, then go to GAP, or to IDLE if `IDLE_GAP`=0.
  - If the watchdog reaches `TIMEOUT_CYCLES-1` without `TxDone`: `EN` ← 0, `Timeout` ← 1, and take the same next-state choice as above.
  - If `TxDone` and the watchdog expiry coincide, `TxDone` wins and no `Timeout` is raised.
- **GAP**
  - Gap counter counts `IDLE_GAP` cycles, then returns to IDLE.
  - `Req` is ignored during the gap.
- `Req` is sampled only in IDLE.
  - A requester must drop `Req` within 1 cycle after `Ack`, otherwise it is eligible again at the next arbitration.
  - Withdrawing `Req` before grant is legal; no `Ack` is issued.
- `TxDone` arriving in IDLE or GAP is ignored.
- Round robin guarantees each continuously requesting source is served within `NUM_REQ` frames.

## Timing
- Reset values:
  - `EN`=0, `DataIN`=0, `Ack`=0, `GrantId`=0, `Busy`=0, `Timeout`=0.
  - State IDLE, `last`=`NUM_REQ-1`, so requester 0 has priority first.
- Reset mid-frame: at the first edge with `Reset`=0, all outputs return to their reset values, `EN` drops immediately, and the frame is abandoned without `Ack` or `Timeout`.
- Latency:
  - `Req` high in IDLE at edge t gives `Ack`, `EN`, `DataIN` valid from t+1.
  - `TxDone` at cycle c gives `EN` low from c+1.
- Minimum frame-to-frame spacing after `TxDone`: `IDLE_GAP`+1 cycles before the next `EN` rise.
- Counter widths: watchdog is `$clog2(TIMEOUT_CYCLES)` bits; gap counter is `$clog2(IDLE_GAP+1)` bits. Neither wraps, since both are cleared on state entry.

## Structure
- Shared package `uart_pkg` contains:
  - `UART_DATA_W`=8.
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} arb_state_t`.
- Sub-module `rr_pick`: purely combinational. Inputs are `Req` and `last`; outputs are `valid` and `index`. It is reused by other shared-resource controllers.
- The FSM, watchdog, gap counter, and output registers live in `uart_tx_arbiter`.

## Test plan
- **Single requester:** `Req`=0001, byte 0 = 8'hEA, `TxDone` pulsed 10 cycles after `EN` rises → `Ack[0]` for 1 cycle, `DataIN`=EA, `EN` high 10 cycles, `Busy` low 3 cycles after `TxDone`.
- **Simultaneous requests after reset:** `Req`=1111 with bytes 11/22/33/44, each frame ended by `TxDone` → grants in order 0,1,2,3 with `DataIN` 11,22,33,44; each `Ack` exactly once.
- **Fairness:** `Req[0]` and `Req[2]` held permanently → `GrantId` sequence 0,2,0,2,0,2.
- **Watchdog:** `TxDone` never asserted → `EN` falls after 64 cycles, `Timeout` pulses once, next pending requester granted after the gap.
- **Coincidence:** `TxDone` in the cycle the watchdog expires → `Timeout` stays 0 and the frame completes normally.
- **Reset mid-frame:** `Reset`=0 during SEND → all outputs are at reset values on the next edge. After release with `Req`=1010, requester 1 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, arbiter state encoding
// and a width helper for counters that may be parameterised down to a single state.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEND,
    ARB_GAP
  } arb_state_t;

  // Counter width for a counter that must hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit searching upward
// from last+1, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    valid    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ byte producers,
// with a per-frame watchdog and a minimum idle gap between frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDLE_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] ReqData,
  output logic [NUM_REQ-1:0]             Ack,
  output logic [$clog2(NUM_REQ)-1:0]     GrantId,
  output logic                           Busy,
  output logic                           EN,
  output logic [UART_DATA_W-1:0]         DataIN,
  input  logic                           TxDone,
  output logic                           Timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = clog2_min1(IDLE_GAP + 1);

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
  // After a frame ends the FSM skips the gap entirely when no idle cycles are required.
  localparam arb_state_t POST_FRAME = (IDLE_GAP == 0) ? ARB_IDLE : ARB_GAP;
  localparam logic       POST_BUSY  = (IDLE_GAP != 0);

  arb_state_t       state;
  logic [IDX_W-1:0] last;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_index;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (Req),
    .last  (last),
    .valid (pick_valid),
    .index (pick_index)
  );

  // NOTE: reset is synchronous and active-low; it is only seen on a rising CLK edge,
  // so a mid-frame reset drops EN at that edge and abandons the frame silently.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state   <= ARB_IDLE;
      last    <= IDX_W'(NUM_REQ - 1);
      wd_cnt  <= '0;
      gap_cnt <= '0;
      Ack     <= '0;
      GrantId <= '0;
      Busy    <= 1'b0;
      EN      <= 1'b0;
      DataIN  <= '0;
      Timeout <= 1'b0;
    end else begin
      Ack     <= '0;
      Timeout <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            GrantId         <= pick_index;
            DataIN          <= ReqData[UART_DATA_W*int'(pick_index) +: UART_DATA_W];
            last            <= pick_index;
            Ack[pick_index] <= 1'b1;
            EN              <= 1'b1;
            Busy            <= 1'b1;
            wd_cnt          <= '0;
            state           <= ARB_SEND;
          end
        end

        ARB_SEND: begin
          // TxDone has priority over a watchdog expiry in the same cycle.
          if (TxDone) begin
            EN      <= 1'b0;
            Busy    <= POST_BUSY;
            gap_cnt <= '0;
            state   <= POST_FRAME;
          end else if (wd_cnt == WD_LAST) begin
            EN      <= 1'b0;
            Timeout <= 1'b1;
            Busy    <= POST_BUSY;
            gap_cnt <= '0;
            state   <= POST_FRAME;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        ARB_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            Busy  <= 1'b0;
            state <= ARB_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: grants are predicted into a queue and
// checked by a monitor whenever an Ack pulse appears.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int IDLE_GAP       = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int BUDGET         = 200;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  Req = '0;
  logic [31:0] ReqData = '0;
  logic        TxDone = 1'b0;
  logic [3:0]  Ack;
  logic [1:0]  GrantId;
  logic        Busy;
  logic        EN;
  logic [7:0]  DataIN;
  logic        Timeout;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   exp_to = 0;
  int   to_seen = 0;
  logic [3:0] hold = '0;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .IDLE_GAP       (IDLE_GAP),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Req     (Req),
    .ReqData (ReqData),
    .Ack     (Ack),
    .GrantId (GrantId),
    .Busy    (Busy),
    .EN      (EN),
    .DataIN  (DataIN),
    .TxDone  (TxDone),
    .Timeout (Timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Ack pulse is matched against the next predicted grant.
  always @(negedge CLK) begin
    exp_t e;
    if (Reset && Ack != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(Ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_onehot", 32'(Ack), 32'(1) << e.idx);
        check("grant_id", 32'(GrantId), 32'(e.idx));
        check("grant_data", 32'(DataIN), 32'(e.data));
        check("grant_en", 32'(EN), 32'd1);
      end
    end
    if (Reset && Timeout) begin
      to_seen++;
      check("timeout_expected", (exp_to > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_to > 0) exp_to--;
    end
  end

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_en"}, 32'(EN), 32'd0);
    check({name, "_data"}, 32'(DataIN), 32'd0);
    check({name, "_ack"}, 32'(Ack), 32'd0);
    check({name, "_grant"}, 32'(GrantId), 32'd0);
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_timeout"}, 32'(Timeout), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  // Waits for EN to rise; the acked requester then drops Req unless it is held.
  task automatic wait_en(input string name, output int ticks);
    ticks = 0;
    while (!EN && ticks < BUDGET) begin
      @(negedge CLK);
      ticks++;
    end
    check({name, "_en_rise"}, 32'(EN), 32'd1);
    Req = Req & ~(Ack & ~hold);
  endtask

  // Called on the first EN-high sample; ends the frame with TxDone so EN is high for len cycles.
  task automatic run_frame(input string name, input int len, input logic [7:0] data);
    int n;
    n = 1;
    for (int i = 1; i < len; i++) begin
      @(negedge CLK);
      if (i == 1) check({name, "_ack_pulse"}, 32'(Ack), 32'd0);
      if (EN) n++;
    end
    check({name, "_data_hold"}, 32'(DataIN), 32'(data));
    TxDone = 1'b1;
    @(negedge CLK);
    TxDone = 1'b0;
    check({name, "_en_len"}, 32'(n), 32'(len));
    check({name, "_en_fall"}, 32'(EN), 32'd0);
  endtask

  task automatic count_en(output int n);
    n = 0;
    while (EN && n < BUDGET) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int ticks;
    int n;

    // Reset state
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    Reset = 1'b1;

    // Single requester, 10-cycle frame, then the idle gap
    ReqData = 32'h0000_00EA;
    push(0, 8'hEA);
    @(negedge CLK);
    Req = 4'b0001;
    wait_en("single", ticks);
    check("single_latency", 32'(ticks), 32'd1);
    run_frame("single", 10, 8'hEA);
    check("single_busy_gap", 32'(Busy), 32'd1);
    @(negedge CLK);
    check("single_busy_gap2", 32'(Busy), 32'd1);
    @(negedge CLK);
    check("single_busy_low", 32'(Busy), 32'd0);

    // Simultaneous requests right after reset: 0,1,2,3
    do_reset();
    ReqData = 32'h4433_2211;
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    Req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_en("simul", ticks);
      if (k > 0) check("simul_spacing", 32'(ticks), 32'(IDLE_GAP + 1));
      run_frame("simul", 3, 8'((k + 1) * 8'h11));
    end

    // Fairness: requesters 0 and 2 never drop Req
    ReqData = 32'h00C2_00A0;
    hold = 4'b0101;
    Req  = 4'b0101;
    for (int k = 0; k < 6; k++) push((k % 2 == 0) ? 0 : 2, (k % 2 == 0) ? 8'hA0 : 8'hC2);
    for (int k = 0; k < 6; k++) begin
      wait_en("fair", ticks);
      run_frame("fair", 2, (k % 2 == 0) ? 8'hA0 : 8'hC2);
    end
    Req  = 4'b0000;
    hold = 4'b0000;

    // Watchdog: last grant was 2, so 3 goes first and 0 waits
    repeat (4) @(negedge CLK);
    ReqData = 32'hD300_00D0;
    push(3, 8'hD3);
    push(0, 8'hD0);
    exp_to = 1;
    Req = 4'b1001;
    wait_en("wdog", ticks);
    count_en(n);
    check("wdog_en_len", 32'(n), 32'(TIMEOUT_CYCLES));
    check("wdog_timeout_pulse", 32'(Timeout), 32'd1);
    wait_en("wdog_next", ticks);
    check("wdog_spacing", 32'(ticks), 32'(IDLE_GAP + 1));
    run_frame("wdog_next", 4, 8'hD0);
    check("wdog_timeouts", 32'(to_seen), 32'd1);

    // TxDone in the same cycle the watchdog would expire
    ReqData = 32'h005A_0000;
    push(2, 8'h5A);
    Req = 4'b0100;
    wait_en("coin", ticks);
    run_frame("coin", TIMEOUT_CYCLES, 8'h5A);
    check("coin_no_timeout", 32'(Timeout), 32'd0);
    check("coin_busy_gap", 32'(Busy), 32'd1);
    repeat (3) @(negedge CLK);
    check("coin_timeouts", 32'(to_seen), 32'd1);

    // Reset in the middle of a frame, then 1 wins over 3
    ReqData = 32'hB300_B177;
    push(0, 8'h77);
    Req = 4'b0001;
    wait_en("midrst", ticks);
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    push(1, 8'hB1);
    push(3, 8'hB3);
    Req = 4'b1010;
    Reset = 1'b1;
    wait_en("post_rst", ticks);
    check("post_rst_latency", 32'(ticks), 32'd1);
    run_frame("post_rst", 3, 8'hB1);
    wait_en("post_rst2", ticks);
    run_frame("post_rst2", 3, 8'hB3);

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("timeouts_total", 32'(to_seen), 32'd1);
    check("timeouts_pending", 32'(exp_to), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
